// File: rtl/osecpu_prog_loader.sv
// Serial program loader for OSECPU: UART 8N1 bytes -> big-endian 32-bit words -> instruction memory.
// Optional trailing XOR checksum byte when LOADER_CSUM_EN is defined.
module osecpu_prog_loader #(
    parameter int CLK_DIV = 434,
    parameter int ADDR_W  = 16
) (
    input  logic              clk_org,
    input  logic              reset,
    input  logic              uart_rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
);
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0]     T_FULL   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]     T_HALF   = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0]     TMR_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
`ifdef LOADER_CSUM_EN
        ST_CSUM   = 3'd3,
`endif
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } ld_state_t;

`ifdef LOADER_CSUM_EN
    localparam ld_state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam ld_state_t ST_AFTER_DATA = ST_DONE;
`endif

    logic              rx_s1_r, rx_s2_r, rx_s3_r;
    rx_state_t         rx_state_r, rx_nxt_s;
    logic [TW-1:0]     tmr_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        rx_byte_r;
    logic              tick_s, half_s, start_ok_s, byte_valid_s, frame_err_s;

    ld_state_t         state_r, state_nxt_s;
    logic [7:0]        len_hi_r;
    logic [ADDR_W-1:0] len_r, len_trunc_s, wc_inc_s;
    logic [15:0]       len16_s;
    logic [31:0]       asm_r;
    logic [1:0]        byte_idx_r;
    logic              wr_s;
    logic [ADDR_W-1:0] mem_addr_r, word_cnt_r;
    logic [31:0]       mem_wdata_r;
    logic              mem_we_r, cpu_reset_r, busy_r, done_r, err_r;
`ifdef LOADER_CSUM_EN
    logic [7:0]        csum_r;
`endif

    // UART receiver next-state and strobes
    always_comb begin
        rx_nxt_s     = rx_state_r;
        tick_s       = (tmr_r == T_FULL);
        half_s       = (tmr_r == T_HALF);
        start_ok_s   = 1'b0;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_s2_r && rx_s3_r) rx_nxt_s = RX_START;
                else                     rx_nxt_s = RX_IDLE;
            end
            RX_START: begin
                if (half_s) begin
                    if (!rx_s2_r) begin
                        rx_nxt_s   = RX_DATA;
                        start_ok_s = 1'b1;
                    end else begin
                        rx_nxt_s = RX_IDLE;
                    end
                end else begin
                    rx_nxt_s = RX_START;
                end
            end
            RX_DATA: begin
                if (tick_s && bit_idx_r == 3'd7) rx_nxt_s = RX_STOP;
                else                             rx_nxt_s = RX_DATA;
            end
            RX_STOP: begin
                if (tick_s) begin
                    rx_nxt_s = RX_IDLE;
                    if (rx_s2_r) byte_valid_s = 1'b1;
                    else         frame_err_s  = 1'b1;
                end else begin
                    rx_nxt_s = RX_STOP;
                end
            end
            default: rx_nxt_s = RX_IDLE;
        endcase
    end

    // UART synchronizer, bit timer and shift register
    always_ff @(posedge clk_org) begin
        if (reset) begin
            rx_s1_r    <= 1'b1;
            rx_s2_r    <= 1'b1;
            rx_s3_r    <= 1'b1;
            rx_state_r <= RX_IDLE;
            tmr_r      <= '0;
            bit_idx_r  <= 3'd0;
            rx_byte_r  <= 8'd0;
        end else begin
            rx_s1_r    <= uart_rx;
            rx_s2_r    <= rx_s1_r;
            rx_s3_r    <= rx_s2_r;
            rx_state_r <= rx_nxt_s;
            if (rx_state_r == RX_IDLE || start_ok_s || tick_s) tmr_r <= '0;
            else                                                tmr_r <= tmr_r + TMR_ONE;
            if (start_ok_s) bit_idx_r <= 3'd0;
            if (rx_state_r == RX_DATA && tick_s) begin
                rx_byte_r <= {rx_s2_r, rx_byte_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end
        end
    end

    assign len16_s     = {len_hi_r, rx_byte_r};
    assign len_trunc_s = ADDR_W'(len16_s);
    assign wc_inc_s    = word_cnt_r + ADDR_ONE;
    assign wr_s        = (state_r == ST_DATA) && byte_valid_s && (byte_idx_r == 2'd3);

    // Loader next-state: framing errors before DONE are fatal
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LEN_HI: begin
                if (frame_err_s)       state_nxt_s = ST_ERROR;
                else if (byte_valid_s) state_nxt_s = ST_LEN_LO;
                else                   state_nxt_s = ST_LEN_HI;
            end
            ST_LEN_LO: begin
                if (frame_err_s)       state_nxt_s = ST_ERROR;
                else if (byte_valid_s) state_nxt_s = (len_trunc_s == '0) ? ST_AFTER_DATA : ST_DATA;
                else                   state_nxt_s = ST_LEN_LO;
            end
            ST_DATA: begin
                if (frame_err_s)                    state_nxt_s = ST_ERROR;
                else if (wr_s && wc_inc_s == len_r) state_nxt_s = ST_AFTER_DATA;
                else                                state_nxt_s = ST_DATA;
            end
`ifdef LOADER_CSUM_EN
            ST_CSUM: begin
                if (frame_err_s)       state_nxt_s = ST_ERROR;
                else if (byte_valid_s) state_nxt_s = (rx_byte_r == csum_r) ? ST_DONE : ST_ERROR;
                else                   state_nxt_s = ST_CSUM;
            end
`endif
            ST_DONE:  state_nxt_s = ST_DONE;
            ST_ERROR: state_nxt_s = ST_ERROR;
            default:  state_nxt_s = ST_ERROR;
        endcase
    end

    // Loader state register
    always_ff @(posedge clk_org) begin
        if (reset) state_r <= ST_LEN_HI;
        else       state_r <= state_nxt_s;
    end

    // Loader datapath and registered outputs
    always_ff @(posedge clk_org) begin
        if (reset) begin
            len_hi_r    <= 8'd0;
            len_r       <= '0;
            asm_r       <= 32'd0;
            byte_idx_r  <= 2'd0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            mem_we_r    <= 1'b0;
            word_cnt_r  <= '0;
            cpu_reset_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_r      <= 8'd0;
`endif
        end else begin
            mem_we_r <= 1'b0;
            if (wr_s) begin
                mem_we_r    <= 1'b1;
                mem_wdata_r <= {asm_r[23:0], rx_byte_r};
                mem_addr_r  <= word_cnt_r;
                word_cnt_r  <= wc_inc_s;
            end
            if (byte_valid_s) begin
                case (state_r)
                    ST_LEN_HI: len_hi_r <= rx_byte_r;
                    ST_LEN_LO: len_r    <= len_trunc_s;
                    ST_DATA: begin
                        asm_r      <= {asm_r[23:0], rx_byte_r};
                        byte_idx_r <= byte_idx_r + 2'd1;
                    end
                    default: ;
                endcase
`ifdef LOADER_CSUM_EN
                if (state_r == ST_LEN_HI || state_r == ST_LEN_LO || state_r == ST_DATA)
                    csum_r <= csum_r ^ rx_byte_r;
`endif
            end
            // busy rises once a start bit is confirmed on the very first byte
            if (state_r == ST_DONE || state_r == ST_ERROR)
                busy_r <= 1'b0;
            else if (state_r == ST_LEN_HI && (start_ok_s || byte_valid_s))
                busy_r <= 1'b1;
            done_r      <= (state_r == ST_DONE);
            err_r       <= (state_r == ST_ERROR);
            cpu_reset_r <= (state_r != ST_DONE);
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;
    assign cpu_reset = cpu_reset_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign word_cnt  = word_cnt_r;
endmodule

// File: tb/tb_osecpu_prog_loader.sv
// Directed bench for osecpu_prog_loader with CLK_DIV=8, bit-accurate UART stimulus.
module tb_osecpu_prog_loader;
    logic        clk_org = 1'b0;
    logic        reset   = 1'b1;
    logic        uart_rx = 1'b1;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, cpu_reset, busy, done, err;
    logic [15:0] word_cnt;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    logic [15:0] wa [64];
    logic [31:0] wd [64];

    logic [7:0] img [10] = '{8'h00, 8'h02, 8'h02, 8'h04, 8'h00, 8'h05, 8'hD3, 8'h00, 8'h40, 8'h00};

    osecpu_prog_loader #(.CLK_DIV(8), .ADDR_W(16)) dut (
        .clk_org(clk_org), .reset(reset), .uart_rx(uart_rx),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
        .word_cnt(word_cnt)
    );

    always #5 clk_org = ~clk_org;

    // write-port monitor
    always @(negedge clk_org) begin
        if (mem_we === 1'b1) begin
            if (we_cnt < 64) begin
                wa[we_cnt] = mem_addr;
                wd[we_cnt] = mem_wdata;
            end
            we_cnt = we_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk_org);
        uart_rx = v;
        repeat (7) @(negedge clk_org);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        drive_bit(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk_org);
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk_org);
        reset = 1'b0;
        repeat (4) @(negedge clk_org);
    endtask

    task automatic send_image();
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
`ifdef LOADER_CSUM_EN
        send_byte(8'h92, 1'b1);
`endif
    endtask

    task automatic test_reset();
        @(negedge clk_org);
        reset = 1'b1;
        repeat (3) @(negedge clk_org);
        if (mem_addr !== 16'd0)   begin errors++; $display("FAIL rst_addr: got %0h expected 0", mem_addr); end
        checks++;
        if (mem_wdata !== 32'd0)  begin errors++; $display("FAIL rst_wdata: got %0h expected 0", mem_wdata); end
        checks++;
        if (mem_we !== 1'b0)      begin errors++; $display("FAIL rst_we: got %b expected 0", mem_we); end
        checks++;
        if (cpu_reset !== 1'b1)   begin errors++; $display("FAIL rst_cpu_reset: got %b expected 1", cpu_reset); end
        checks++;
        if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {busy, done, err}); end
        checks++;
        if (word_cnt !== 16'd0)   begin errors++; $display("FAIL rst_word_cnt: got %0d expected 0", word_cnt); end
        checks++;
        reset = 1'b0;
        repeat (4) @(negedge clk_org);
    endtask

    task automatic test_image();
        int base;
        do_reset();
        base = we_cnt;
        send_byte(img[0], 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL img_busy: got %b expected 1", busy); end
        for (int i = 1; i < 10; i++) send_byte(img[i], 1'b1);
`ifdef LOADER_CSUM_EN
        send_byte(8'h92, 1'b1);
`endif
        checks++;
        if (we_cnt - base != 2) begin errors++; $display("FAIL img_we_count: got %0d expected 2", we_cnt - base); end
        checks++;
        if (wa[base] !== 16'd0 || wd[base] !== 32'h02040005)
            begin errors++; $display("FAIL img_word0: got %0h@%0h expected 02040005@0", wd[base], wa[base]); end
        checks++;
        if (wa[base+1] !== 16'd1 || wd[base+1] !== 32'hD3004000)
            begin errors++; $display("FAIL img_word1: got %0h@%0h expected d3004000@1", wd[base+1], wa[base+1]); end
        checks++;
        if ({done, cpu_reset, busy, err} !== 4'b1000)
            begin errors++; $display("FAIL img_flags: got %b expected 1000", {done, cpu_reset, busy, err}); end
        checks++;
        if (word_cnt !== 16'd2) begin errors++; $display("FAIL img_word_cnt: got %0d expected 2", word_cnt); end
        checks++;
        if (mem_addr !== 16'd1 || mem_wdata !== 32'hD3004000)
            begin errors++; $display("FAIL img_hold: got %0h@%0h expected d3004000@1", mem_wdata, mem_addr); end
        // bytes after DONE are ignored
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        checks++;
        if (we_cnt - base != 2 || done !== 1'b1 || word_cnt !== 16'd2)
            begin errors++; $display("FAIL done_ignore: got we=%0d done=%b cnt=%0d expected 2 1 2", we_cnt - base, done, word_cnt); end
    endtask

    task automatic test_zero_len();
        int base;
        do_reset();
        base = we_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef LOADER_CSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        checks++;
        if (we_cnt - base != 0) begin errors++; $display("FAIL zero_we: got %0d expected 0", we_cnt - base); end
        checks++;
        if ({done, cpu_reset, err} !== 3'b100)
            begin errors++; $display("FAIL zero_flags: got %b expected 100", {done, cpu_reset, err}); end
    endtask

    task automatic test_frame_err();
        int base;
        do_reset();
        base = we_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h02, 1'b0);
        checks++;
        if ({err, cpu_reset, busy, done} !== 4'b1100)
            begin errors++; $display("FAIL ferr_flags: got %b expected 1100", {err, cpu_reset, busy, done}); end
        for (int i = 3; i < 10; i++) send_byte(img[i], 1'b1);
        checks++;
        if (we_cnt - base != 0) begin errors++; $display("FAIL ferr_we: got %0d expected 0", we_cnt - base); end
        checks++;
        if ({err, done, cpu_reset} !== 3'b101)
            begin errors++; $display("FAIL ferr_sticky: got %b expected 101", {err, done, cpu_reset}); end
    endtask

    task automatic test_glitch();
        do_reset();
        @(negedge clk_org);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk_org);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk_org);
        checks++;
        if ({busy, done, err} !== 3'b000)
            begin errors++; $display("FAIL glitch_flags: got %b expected 000", {busy, done, err}); end
        // a clean zero-length image proves the loader is still waiting for LEN_HI
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef LOADER_CSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        checks++;
        if ({done, err} !== 2'b10) begin errors++; $display("FAIL glitch_state: got %b expected 10", {done, err}); end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b1);
        checks++;
        if (busy !== 1'b1 || word_cnt !== 16'd1)
            begin errors++; $display("FAIL mid_pre: got busy=%b cnt=%0d expected 1 1", busy, word_cnt); end
        @(negedge clk_org);
        reset = 1'b1;
        @(negedge clk_org);
        checks++;
        if (word_cnt !== 16'd0 || cpu_reset !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL mid_reset: got cnt=%0d cpu_reset=%b busy=%b expected 0 1 0", word_cnt, cpu_reset, busy); end
        reset = 1'b0;
        repeat (4) @(negedge clk_org);
        base = we_cnt;
        send_image();
        checks++;
        if (we_cnt - base != 2 || wd[base] !== 32'h02040005 || wd[base+1] !== 32'hD3004000 || wa[base+1] !== 16'd1)
            begin errors++; $display("FAIL mid_reload: got we=%0d w0=%0h w1=%0h expected 2 02040005 d3004000", we_cnt - base, wd[base], wd[base+1]); end
        checks++;
        if ({done, cpu_reset, err} !== 3'b100 || word_cnt !== 16'd2)
            begin errors++; $display("FAIL mid_done: got %b cnt=%0d expected 100 2", {done, cpu_reset, err}, word_cnt); end
    endtask

`ifdef LOADER_CSUM_EN
    task automatic test_csum();
        int base;
        logic [7:0] im2 [6];
        im2 = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(im2[i], 1'b1);
        send_byte(8'h45, 1'b1);
        checks++;
        if ({done, err, cpu_reset} !== 3'b100)
            begin errors++; $display("FAIL csum_good: got %b expected 100", {done, err, cpu_reset}); end
        do_reset();
        base = we_cnt;
        for (int i = 0; i < 6; i++) send_byte(im2[i], 1'b1);
        send_byte(8'h46, 1'b1);
        checks++;
        if ({done, err, cpu_reset} !== 3'b011)
            begin errors++; $display("FAIL csum_bad: got %b expected 011", {done, err, cpu_reset}); end
        checks++;
        if (we_cnt - base != 1 || wa[base] !== 16'd0 || wd[base] !== 32'h11223344)
            begin errors++; $display("FAIL csum_bad_word: got we=%0d %0h@%0h expected 1 11223344@0", we_cnt - base, wd[base], wa[base]); end
    endtask
`endif

    initial begin
        test_reset();
        test_image();
        test_zero_len();
        test_frame_err();
        test_glitch();
        test_reset_mid();
`ifdef LOADER_CSUM_EN
        test_csum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
